// File: rtl/multi_pulser_pkg.sv
// -----------------------------------------------------------------------------
// multi_pulser_pkg
// Shared definitions for the multi-channel pulse/strobe generator:
//   - output mode encodings (pulse vs. toggle)
//   - per-channel state encodings (IDLE / RUN)
//   - elaboration helper that checks a reset period fits in the counter width
// No ports (package).
// -----------------------------------------------------------------------------
package multi_pulser_pkg;

  // Output mode captured per channel.
  localparam logic pulse_mode_pulse  = 1'b0;
  localparam logic pulse_mode_toggle = 1'b1;

  // Channel state. The running output is a direct view of this register.
  localparam logic [0:0] st_idle = 1'b0;
  localparam logic [0:0] st_run  = 1'b1;

  // True when period value p is representable in w unsigned bits.
  function automatic bit period_fits(input longint unsigned p, input int unsigned w);
    if (w >= 64) return 1'b1;
    return p < (64'd1 << w);
  endfunction

endpackage

// File: rtl/multi_pulser_if.sv
// -----------------------------------------------------------------------------
// multi_pulser_if
// Bundles the control and status signals of multi_pulser.
//   enable       per-channel count qualifier
//   load         per-channel load strobe (level-sampled every edge)
//   load_period  shared period bus captured on load
//   load_toggle  shared mode bit captured on load (1 = toggle output)
//   load_oneshot shared mode bit captured on load (1 = stop after one event)
//   sync         global phase restart of all running channels
//   out          registered pulse/toggle outputs
//   running      channel is counting
// Handshake semantics: there is no valid/ready pair. Every input is sampled
// on every rising clock edge and every output is a plain registered level;
// a strobe held for k edges acts k times.
// master = the controlling block, slave = the pulser.
// -----------------------------------------------------------------------------
interface multi_pulser_if #(
  parameter int unsigned channels = 4,
  parameter int unsigned width    = 16
);
  logic [channels-1:0] enable;
  logic [channels-1:0] load;
  logic [width-1:0]    load_period;
  logic                load_toggle;
  logic                load_oneshot;
  logic                sync;
  logic [channels-1:0] out;
  logic [channels-1:0] running;

  modport master (
    output enable, load, load_period, load_toggle, load_oneshot, sync,
    input  out, running
  );

  modport slave (
    input  enable, load, load_period, load_toggle, load_oneshot, sync,
    output out, running
  );
endinterface

// File: rtl/pulser_channel.sv
// -----------------------------------------------------------------------------
// pulser_channel
// One channel of the programmable pulser: period/counter registers, mode bits,
// IDLE/RUN state and the registered output.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   enable_i                count qualifier
//   load_i                  capture load_period_i / mode bits, restart count
//   load_period_i           period to capture (0 = go idle)
//   load_toggle_i           mode to capture: 1 = toggle output
//   load_oneshot_i          mode to capture: 1 = finish after first terminal
//   sync_i                  restart counter if running
//   out_o                   registered pulse / toggle output
//   running_o               channel state (1 = RUN)
// Priority: reset > load > sync > terminal/increment.
// -----------------------------------------------------------------------------
module pulser_channel
  import multi_pulser_pkg::*;
#(
  parameter int unsigned      width          = 16,
  parameter logic [width-1:0] default_period = '0,
  parameter logic             default_toggle = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             load_i,
  input  logic [width-1:0] load_period_i,
  input  logic             load_toggle_i,
  input  logic             load_oneshot_i,
  input  logic             sync_i,
  output logic             out_o,
  output logic             running_o
);

  logic [width-1:0] period_q,  period_d;
  logic [width-1:0] counter_q, counter_d;
  logic             toggle_q,  toggle_d;
  logic             oneshot_q, oneshot_d;
  logic [0:0]       state_q,   state_d;
  logic             out_q,     out_d;
  logic             terminal;

  // RUN always implies period_q != 0, so period_q - 1 never underflows
  // while it matters.
  assign terminal = (state_q == st_run) && enable_i &&
                    (counter_q == period_q - width'(1));

  always_comb begin
    period_d  = period_q;
    counter_d = counter_q;
    toggle_d  = toggle_q;
    oneshot_d = oneshot_q;
    state_d   = state_q;
    // Pulse mode drops back to 0 unless a terminal event fires below;
    // toggle mode holds its level.
    out_d     = (toggle_q == pulse_mode_toggle) ? out_q : 1'b0;

    if (load_i) begin
      period_d  = load_period_i;
      toggle_d  = load_toggle_i;
      oneshot_d = load_oneshot_i;
      counter_d = '0;
      state_d   = (load_period_i != '0) ? st_run : st_idle;
      out_d     = (load_toggle_i == pulse_mode_toggle) ? out_q : 1'b0;
    end else if (sync_i) begin
      // A sync on a terminal cycle swallows that terminal event.
      if (state_q == st_run) counter_d = '0;
    end else if (terminal) begin
      counter_d = '0;
      out_d     = (toggle_q == pulse_mode_toggle) ? ~out_q : 1'b1;
      if (oneshot_q) state_d = st_idle;
    end else if ((state_q == st_run) && enable_i) begin
      counter_d = counter_q + width'(1);
    end else if (state_q == st_idle) begin
      counter_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      period_q  <= default_period;
      counter_q <= '0;
      toggle_q  <= default_toggle;
      oneshot_q <= 1'b0;
      state_q   <= (default_period != '0) ? st_run : st_idle;
      out_q     <= 1'b0;
    end else begin
      period_q  <= period_d;
      counter_q <= counter_d;
      toggle_q  <= toggle_d;
      oneshot_q <= oneshot_d;
      state_q   <= state_d;
      out_q     <= out_d;
    end
  end

  assign out_o     = out_q;
  assign running_o = (state_q == st_run);

endmodule

// File: rtl/multi_pulser.sv
// -----------------------------------------------------------------------------
// multi_pulser
// Multi-channel programmable pulse/strobe generator. Each channel counts its
// own enable qualifier and emits a one-cycle pulse, or toggles its output,
// every N enabled cycles. N and the mode bits are loaded at runtime.
// Ports:
//   clock   sole clock, rising edge
//   reset   synchronous, active-high
//   bus     multi_pulser_if.slave: enable/load/load_period/load_toggle/
//           load_oneshot/sync in, out/running out
// Parameters: channels (>=1), width (counter bits), default_period (reset
// period, must fit in width bits, 0 = idle), default_toggle (reset mode).
// -----------------------------------------------------------------------------
module multi_pulser
  import multi_pulser_pkg::*;
#(
  parameter int unsigned channels       = 4,
  parameter int unsigned width          = 16,
  parameter int unsigned default_period = 0,
  parameter bit          default_toggle = 1'b0
) (
  input  logic           clock,
  input  logic           reset,
  multi_pulser_if.slave  bus
);

  if (channels < 1) begin : g_bad_channels
    $error("multi_pulser: channels must be at least 1");
  end

  if (!period_fits(longint'(default_period), width)) begin : g_bad_default_period
    $error("multi_pulser: default_period does not fit in width bits");
  end

  localparam logic [width-1:0] reset_period = width'(default_period);

  // Shared load bus and sync fan out to every channel; only the per-channel
  // load strobe decides which channel captures it.
  for (genvar i = 0; i < channels; i++) begin : g_ch
    pulser_channel #(
      .width          (width),
      .default_period (reset_period),
      .default_toggle (default_toggle)
    ) u_ch (
      .clock          (clock),
      .reset          (reset),
      .enable_i       (bus.enable[i]),
      .load_i         (bus.load[i]),
      .load_period_i  (bus.load_period),
      .load_toggle_i  (bus.load_toggle),
      .load_oneshot_i (bus.load_oneshot),
      .sync_i         (bus.sync),
      .out_o          (bus.out[i]),
      .running_o      (bus.running[i])
    );
  end

endmodule
